// File: rtl/seed_capture_pkg.sv
// Shared definitions for the seed capture block: FSM encoding, default
// parameter values and the zero-seed substitution helper.
`timescale 1ns/1ps
package seed_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_PRESS = 2'd0,
    LOAD       = 2'd1,
    RUN        = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [15:0] DEFAULT_FALLBACK_SEED   = 16'hACE1;

  // An all-zero seed would lock an LFSR, so a zero count is replaced.
  function automatic logic [15:0] seedOrFallback(input logic [15:0] count,
                                                 input logic [15:0] fallback);
    return (count == 16'h0000) ? fallback : count;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer and stability-count debouncer for an active-low
// push-button; emits a one-cycle press on each accepted released->pressed edge.
`timescale 1ns/1ps
module key_debounce
  import seed_capture_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_press;
  logic        r_armed;
  logic [1:0]  r_fill;
  logic [15:0] r_stable;
  logic        w_differs;
  logic        w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_stable == (DEBOUNCE_CYCLES - 16'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_level  <= 1'b1;
      r_press  <= 1'b0;
      r_armed  <= 1'b0;
      r_fill   <= 2'b00;
      r_stable <= 16'd0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      // Presses count only once a genuine released sample has been seen,
      // so a key held through reset never fires.
      if (r_fill[1] && r_sync2) begin
        r_armed <= 1'b1;
      end
      if (!w_differs || w_accept) begin
        r_stable <= 16'd0;
      end else begin
        r_stable <= r_stable + 16'd1;
      end
      if (w_accept) begin
        r_level <= r_sync2;
      end
      r_press <= w_accept && !r_sync2 && r_armed;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/seed_capture.sv
// Captures a free-running entropy count on a debounced key press and hands it
// to a pseudo-random generator as a seed, with a load handshake and reseed.
`timescale 1ns/1ps
module seed_capture
  import seed_capture_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [15:0] FALLBACK_SEED   = DEFAULT_FALLBACK_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic        reseed_req,
  output logic [15:0] srand,
  output logic        init_srand,
  output logic        seed_valid
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_entropy;
  logic [15:0] r_srand;
  logic        r_initSrand;
  logic        r_seedValid;
  logic        w_keyLevel;
  logic        w_press;
  logic        w_capture;
  logic        w_runOut;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_keyDebounce (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .level (w_keyLevel),
    .press (w_press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_PRESS;
    end else begin
      r_state <= w_next;
    end
  end

  // The run outputs rise only once RUN has settled and drop on the same
  // edge that accepts a reseed.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      WAIT_PRESS: begin
        if (w_press && !w_keyLevel) begin
          w_capture = 1'b1;
          w_next    = LOAD;
        end
      end
      LOAD: begin
        w_next = RUN;
      end
      RUN: begin
        if (reseed_req) begin
          w_next = WAIT_PRESS;
        end
      end
      default: begin
        w_next = WAIT_PRESS;
      end
    endcase
    w_runOut = (r_state == RUN) && (w_next == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entropy   <= 16'h0000;
      r_srand     <= 16'h0000;
      r_initSrand <= 1'b0;
      r_seedValid <= 1'b0;
    end else begin
      r_entropy   <= r_entropy + 16'd1;
      r_initSrand <= w_runOut;
      r_seedValid <= w_runOut;
      if (w_capture) begin
        r_srand <= seedOrFallback(r_entropy, FALLBACK_SEED);
      end
    end
  end

  assign srand      = r_srand;
  assign init_srand = r_initSrand;
  assign seed_valid = r_seedValid;

endmodule

// File: tb/tb_seed_capture.sv
// Scoreboard bench for seed_capture: stimulus queues expected output changes,
// a negedge monitor pops and compares each change the DUT presents.
`timescale 1ns/1ps
module tb_seed_capture;

  localparam logic [15:0] DEB      = 16'd4;
  localparam logic [15:0] FALLBACK = 16'hACE1;

  typedef struct {
    logic [15:0] srand;
    logic        init;
    logic        valid;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        key_n      = 1'b1;
  logic        reseed_req = 1'b0;
  logic [15:0] srand;
  logic        init_srand;
  logic        seed_valid;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] ecnt     = 16'h0000;
  bit          monOn    = 1'b0;
  bit          done     = 1'b0;
  logic [15:0] prevSrand = 16'h0000;
  logic        prevInit  = 1'b0;
  logic        prevValid = 1'b0;

  logic [15:0] seedB;
  logic [15:0] seedC;
  int          c0;

  seed_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .FALLBACK_SEED  (FALLBACK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .reseed_req(reseed_req),
    .srand     (srand),
    .init_srand(init_srand),
    .seed_valid(seed_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected entropy count: cleared by reset, +1 per rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 16'h0000;
    else      ecnt <= ecnt + 16'd1;
  end

  // Seed captured for a key first sampled low while the count is p.
  function automatic logic [15:0] expSeed(input logic [15:0] p);
    logic [15:0] v;
    v = p + 16'd2 + DEB;
    return (v == 16'h0000) ? FALLBACK : v;
  endfunction

  always @(negedge clk) begin
    if (monOn && ((srand !== prevSrand) || (init_srand !== prevInit) ||
                  (seed_valid !== prevValid))) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_change: got srand=%h init=%b valid=%b at cyc %0d, required no change",
                 srand, init_srand, seed_valid, cyc);
      end else begin
        monE = expQ.pop_front();
        if (srand !== monE.srand || init_srand !== monE.init ||
            seed_valid !== monE.valid || cyc != monE.cyc) begin
          failures++;
          $display("[TB] FAIL %s: got srand=%h init=%b valid=%b cyc=%0d, required srand=%h init=%b valid=%b cyc=%0d",
                   monE.name, srand, init_srand, seed_valid, cyc,
                   monE.srand, monE.init, monE.valid, monE.cyc);
        end
      end
    end
    prevSrand = srand;
    prevInit  = init_srand;
    prevValid = seed_valid;
  end

  task automatic applyStimulus(input logic keyN, input logic reseed);
    key_n      = keyN;
    reseed_req = reseed;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] s,
                             input logic i, input logic v);
    checks++;
    if (srand !== s) begin
      failures++;
      $display("[TB] FAIL %s_srand: got %h, required %h", name, srand, s);
    end
    checks++;
    if (init_srand !== i) begin
      failures++;
      $display("[TB] FAIL %s_init: got %b, required %b", name, init_srand, i);
    end
    checks++;
    if (seed_valid !== v) begin
      failures++;
      $display("[TB] FAIL %s_valid: got %b, required %b", name, seed_valid, v);
    end
  endtask

  task automatic expectEvent(input logic [15:0] s, input logic i, input logic v,
                             input int c, input string name);
    exp_t e;
    e.srand = s;
    e.init  = i;
    e.valid = v;
    e.cyc   = c;
    e.name  = name;
    expQ.push_back(e);
  endtask

  // Called at a negedge: press the key and queue capture plus run entry.
  task automatic pressCapture(input string name, input logic [15:0] seed,
                              input bit expectRun);
    applyStimulus(1'b0, 1'b0);
    expectEvent(seed, 1'b0, 1'b0, cyc + 7, {name, "_capture"});
    if (expectRun) expectEvent(seed, 1'b1, 1'b1, cyc + 9, {name, "_run"});
  endtask

  task automatic waitCount(input logic [15:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ecnt != target && n < 70000);
    checks++;
    if (ecnt != target) begin
      failures++;
      $display("[TB] FAIL wait_count: got %h, required %h", ecnt, target);
    end
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d pending events, required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic pulseReseed();
    applyStimulus(key_n, 1'b1);
    @(negedge clk);
    applyStimulus(key_n, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 checkOutput("reset_state", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    monOn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      checkOutput("idle", 16'h0000, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("glitch", 16'h0000, 1'b0, 1'b0);

    #2 rst = 1'b0;
    #1 checkOutput("reset_b", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    waitCount(16'h0010);
    pressCapture("first", 16'h0016, 1'b1);
    waitDrain("first", 30);
    checkOutput("first_run", 16'h0016, 1'b1, 1'b1);

    @(negedge clk);
    expectEvent(16'h0016, 1'b0, 1'b0, cyc + 1, "reseed_drop");
    pulseReseed();
    repeat (30) @(negedge clk);
    waitDrain("reseed", 5);
    checkOutput("reseed_held", 16'h0016, 1'b0, 1'b0);

    pulseReseed();
    repeat (5) @(negedge clk);
    checkOutput("reseed_in_wait", 16'h0016, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    seedB = expSeed(ecnt);
    pressCapture("second", seedB, 1'b1);
    waitDrain("second", 30);
    checkOutput("second_run", seedB, 1'b1, 1'b1);
    checks++;
    if (srand === 16'h0016) begin
      failures++;
      $display("[TB] FAIL second_differs: got %h, required a value other than 0016", srand);
    end

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("press_in_run", seedB, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    c0 = cyc;
    repeat (6) @(negedge clk);
    expectEvent(seedB, 1'b0, 1'b0, c0 + 7, "press_vs_reseed");
    pulseReseed();
    repeat (30) @(negedge clk);
    waitDrain("press_vs_reseed", 5);
    checkOutput("press_discarded", seedB, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    waitCount(16'hFFFA);
    pressCapture("wrap", 16'hACE1, 1'b1);
    waitDrain("wrap", 30);
    checkOutput("wrap_run", 16'hACE1, 1'b1, 1'b1);

    @(negedge clk);
    expectEvent(16'hACE1, 1'b0, 1'b0, cyc + 1, "reseed_wrap");
    pulseReseed();
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    pressCapture("load_abort", expSeed(ecnt), 1'b0);
    c0 = cyc;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    expectEvent(16'h0000, 1'b0, 1'b0, c0 + 8, "reset_drop");
    #1 checkOutput("reset_in_load", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    waitDrain("held_key", 5);
    checkOutput("held_key_after_reset", 16'h0000, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    seedC = expSeed(ecnt);
    pressCapture("recover", seedC, 1'b1);
    waitDrain("recover", 30);
    checkOutput("recover_run", seedC, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      failures++;
      $display("[TB] FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule
